// File: rtl/dg0045_fetch_bridge.sv
// Fetch bridge: scans the core's multiplexed PC in two halves and fetches the
// matching instruction byte from program memory. Optional debounce: DG0045_FETCH_DEBOUNCE_EN.
module dg0045_fetch_bridge #(
  parameter int SETTLE_CYC = 1
) (
  input  logic       clk_in,
  input  logic       RESET,
  input  logic [4:0] pc_hl,
  output logic       pc_mux,
  output logic [7:0] rom_data,
  output logic       fetch_valid,
  output logic [9:0] mem_addr,
  output logic       mem_req,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata
);

  typedef enum logic [1:0] {S_LO, S_HI, S_CMP, S_REQ} state_t;

  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYC);

  state_t     state, state_nxt;
  logic [2:0] settle_cnt, settle_cnt_nxt;
  logic [4:0] lo, lo_nxt;
  logic [4:0] hi, hi_nxt;
  logic       pc_mux_nxt;
  logic [7:0] rom_data_nxt;
  logic       fetch_valid_nxt;
  logic [9:0] mem_addr_nxt;
  logic       mem_req_nxt;
  logic [9:0] new_addr;
  logic       addr_settled;

  assign new_addr = {hi, lo};

`ifdef DG0045_FETCH_DEBOUNCE_EN
  logic [9:0] prev_addr, prev_addr_nxt;

  // A fetch is only allowed once two consecutive scans agree.
  assign addr_settled = (new_addr == prev_addr);

  always_ff @(posedge clk_in or negedge RESET) begin
    if (!RESET) begin
      prev_addr <= 10'h000;
    end else begin
      prev_addr <= prev_addr_nxt;
    end
  end

  always_comb begin
    prev_addr_nxt = prev_addr;
    if (state == S_CMP) begin
      prev_addr_nxt = new_addr;
    end
  end
`else
  assign addr_settled = 1'b1;
`endif

  always_ff @(posedge clk_in or negedge RESET) begin
    if (!RESET) begin
      state       <= S_LO;
      settle_cnt  <= 3'd0;
      lo          <= 5'd0;
      hi          <= 5'd0;
      pc_mux      <= 1'b0;
      rom_data    <= 8'h00;
      fetch_valid <= 1'b0;
      mem_addr    <= 10'h000;
      mem_req     <= 1'b0;
    end else begin
      state       <= state_nxt;
      settle_cnt  <= settle_cnt_nxt;
      lo          <= lo_nxt;
      hi          <= hi_nxt;
      pc_mux      <= pc_mux_nxt;
      rom_data    <= rom_data_nxt;
      fetch_valid <= fetch_valid_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_req     <= mem_req_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    settle_cnt_nxt  = settle_cnt;
    lo_nxt          = lo;
    hi_nxt          = hi;
    rom_data_nxt    = rom_data;
    fetch_valid_nxt = fetch_valid;
    mem_addr_nxt    = mem_addr;
    mem_req_nxt     = mem_req;

    case (state)
      S_LO: begin
        if (settle_cnt == SETTLE_LAST) begin
          lo_nxt         = pc_hl;
          settle_cnt_nxt = 3'd0;
          state_nxt      = S_HI;
        end else begin
          settle_cnt_nxt = settle_cnt + 3'd1;
        end
      end
      S_HI: begin
        if (settle_cnt == SETTLE_LAST) begin
          hi_nxt         = pc_hl;
          settle_cnt_nxt = 3'd0;
          state_nxt      = S_CMP;
        end else begin
          settle_cnt_nxt = settle_cnt + 3'd1;
        end
      end
      S_CMP: begin
        if (fetch_valid && (new_addr == mem_addr)) begin
          state_nxt = S_LO;
        end else if (!addr_settled) begin
          state_nxt = S_LO;
        end else begin
          mem_addr_nxt    = new_addr;
          fetch_valid_nxt = 1'b0;
          mem_req_nxt     = 1'b1;
          state_nxt       = S_REQ;
        end
      end
      S_REQ: begin
        // No timeout: the request is held until memory answers.
        if (mem_ack) begin
          rom_data_nxt    = mem_rdata;
          fetch_valid_nxt = 1'b1;
          mem_req_nxt     = 1'b0;
          state_nxt       = S_LO;
        end
      end
      default: begin
        state_nxt = S_LO;
      end
    endcase

    pc_mux_nxt = (state_nxt == S_HI);
  end

endmodule

// File: doc/dg0045_fetch_bridge.md
DG0045_FETCH_BRIDGE -- requirements
Module: dg0045_fetch_bridge

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 1, legal range 0..7: idle cycles after a pc_mux change before pc_hl is sampled.
REQ-002 The block SHALL have port clk_in, input, 1 bit: clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port pc_hl, input, 5 bits: multiplexed program counter from the core; {PU[3:0],PL[5]} when pc_mux=1, PL[4:0] when pc_mux=0.
REQ-005 The block SHALL have port pc_mux, output, 1 bit: half-select driven to the core's PC_MUX pin.
REQ-006 The block SHALL have port rom_data, output, 8 bits: instruction byte driven to the core's mainROM input.
REQ-007 The block SHALL have port fetch_valid, output, 1 bit: high when rom_data belongs to the address in mem_addr.
REQ-008 The block SHALL have port mem_addr, output, 10 bits: program memory address {PU,PL}.
REQ-009 The block SHALL have port mem_req, output, 1 bit: read request to program memory.
REQ-010 The block SHALL have port mem_ack, input, 1 bit: read acknowledge; mem_rdata is valid in the same cycle.
REQ-011 The block SHALL have port mem_rdata, input, 8 bits: read data from program memory.

Function
REQ-012 The FSM SHALL have exactly the states S_LO, S_HI, S_CMP and S_REQ; every output SHALL be registered.
REQ-013 In S_LO, pc_mux SHALL be 0; after SETTLE_CYC cycles in the state, lo<=pc_hl on the next edge and the FSM SHALL go to S_HI.
REQ-014 In S_HI, pc_mux SHALL be 1; after SETTLE_CYC cycles in the state, hi<=pc_hl on the next edge and the FSM SHALL go to S_CMP.
REQ-015 One scan SHALL take 2*(SETTLE_CYC+1)+1 cycles; the assembled address SHALL be new_addr={hi[4:0],lo[4:0]}, giving PU=hi[4:1], PL={hi[0],lo}.
REQ-016 In S_CMP, if fetch_valid=1 and new_addr==mem_addr, the FSM SHALL return to S_LO with no request.
REQ-017 Otherwise, in S_CMP, mem_addr<=new_addr, fetch_valid<=0 and mem_req<=1, and the FSM SHALL go to S_REQ.
REQ-018 In S_REQ, mem_req and mem_addr SHALL be held stable until mem_ack=1 is sampled.
REQ-019 On that mem_ack edge: rom_data<=mem_rdata, fetch_valid<=1, mem_req<=0, and the FSM SHALL go to S_LO.
REQ-020 mem_ack SHALL be ignored outside S_REQ; an ack in the first cycle of mem_req=1 SHALL be accepted.
REQ-021 rom_data SHALL keep its previous value from the start of a fetch until that fetch's ack, and SHALL never change outside the ack edge.
REQ-022 If the core PC changes during S_REQ, the outstanding fetch SHALL complete unchanged; the next scan SHALL detect the new address.
REQ-023 There SHALL be no timeout; a missing mem_ack SHALL hold the block in S_REQ indefinitely.

Reset
REQ-024 RESET=0 SHALL immediately force the following, including mid-request (mem_req drops without waiting for ack): state S_LO, settle counter 0, pc_mux 0, rom_data 8'h00 (NOP), fetch_valid 0, mem_req 0, mem_addr 10'h000, lo/hi 0.
REQ-025 After RESET, the first scan SHALL always issue a fetch, because fetch_valid=0.

Configuration
REQ-026 With macro DG0045_FETCH_DEBOUNCE_EN defined, S_CMP SHALL issue a fetch only when new_addr equals the new_addr of the immediately preceding scan (held in a prev_addr register, reset 0); otherwise it SHALL store prev_addr and return to S_LO.
REQ-027 With DG0045_FETCH_DEBOUNCE_EN undefined, a single scan SHALL suffice and no prev_addr register SHALL exist.

Verification (SETTLE_CYC=1, macro undefined unless stated)
REQ-028 Release RESET with core PC=0, ack after 1 cycle with 8'h00 -> mem_addr 10'h000, one mem_req pulse, fetch_valid=1, rom_data 8'h00.
REQ-029 Core PC PU=4'hF, PL=6'h2A (pc_hl 5'h1F when pc_mux=1, 5'h0A when pc_mux=0), ack with 8'hC5 -> mem_addr 10'h3EA, rom_data 8'hC5, fetch_valid 1.
REQ-030 PC held at 10'h3EA for 20 scans -> mem_req stays 0 and rom_data stays 8'hC5.
REQ-031 New PC 10'h155, mem_ack delayed 5 cycles -> mem_req and mem_addr 10'h155 are stable for all 5 cycles, rom_data stays 8'hC5 until ack, then takes mem_rdata.
REQ-032 RESET pulled low while mem_req=1 -> mem_req=0, rom_data=8'h00 and pc_mux=0 in the same cycle, before any clock edge.
REQ-033 PC glitches to 10'h001 for one scan and then returns to 10'h3EA -> with DG0045_FETCH_DEBOUNCE_EN, no request; without it, requests to 10'h001 and then to 10'h3EA.
